// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: round-robin issue of two FP requesters onto one
// multi-cycle FP unit (start/done), with a watchdog that aborts hung ops.
// Ports: clk, rst (async, active-high); req0_*/req1_* valid/ready/op/a/b;
//   unit_start/abort/op/a/b out, unit_done/result/flags in;
//   resp_valid/ready/id/result/flags/timeout response channel.
// Optional macro FPU_ARB_NAN_BYPASS_EN: NaN operands answered without the unit.
module fpu_issue_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        unit_start,
  output logic        unit_abort,
  output logic [1:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_result,
  input  logic [4:0]  unit_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_flags,
  output logic        resp_timeout
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt0;
  logic             gnt1;
  logic             grant;
  logic             expire;
  logic             hs;
  logic [1:0]       g_op;
  logic [31:0]      g_a;
  logic [31:0]      g_b;
  logic             bypass;

`ifdef FPU_ARB_NAN_BYPASS_EN
  logic nan_q;
  logic snan_q;
  logic g_nan;
  logic g_snan;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // NaN check is taken at grant and registered; ISSUE then
  // routes straight to RESP without pulsing the unit.
  always_comb begin
    g_nan  = is_nan(g_a) | is_nan(g_b);
    g_snan = (is_nan(g_a) & ~g_a[22])
           | (is_nan(g_b) & ~g_b[22]);
  end

  assign bypass = nan_q;
`else
  assign bypass = 1'b0;
`endif

  // Ready is masked by rst so both ports read 0 while in reset.
  always_comb begin
    gnt0   = req0_valid & (~req1_valid | ~ptr_q);
    gnt1   = req1_valid & (~req0_valid | ptr_q);
    grant  = (state_q == S_IDLE) & (gnt0 | gnt1) & ~rst;
    g_op   = gnt1 ? req1_op : req0_op;
    g_a    = gnt1 ? req1_a : req0_a;
    g_b    = gnt1 ? req1_b : req0_b;
    expire = (state_q == S_WAIT) & ~unit_done
           & (cnt_q == CNT_LAST);
    hs     = (state_q == S_RESP) & resp_ready;
  end

  assign req0_ready = grant & gnt0;
  assign req1_ready = grant & gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    unit_start = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        unit_start = ~bypass;
        state_d    = bypass ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (unit_done | expire) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= 1'b0;
      cnt_q        <= '0;
      unit_abort   <= 1'b0;
      unit_op      <= '0;
      unit_a       <= '0;
      unit_b       <= '0;
      resp_id      <= 1'b0;
      resp_result  <= '0;
      resp_flags   <= '0;
      resp_timeout <= 1'b0;
`ifdef FPU_ARB_NAN_BYPASS_EN
      nan_q        <= 1'b0;
      snan_q       <= 1'b0;
`endif
    end else begin
      unit_abort <= expire;
      if (grant) begin
        unit_op <= g_op;
        unit_a  <= g_a;
        unit_b  <= g_b;
        resp_id <= gnt1;
`ifdef FPU_ARB_NAN_BYPASS_EN
        nan_q   <= g_nan;
        snan_q  <= g_snan;
`endif
      end
      if (state_q == S_ISSUE) begin
        cnt_q <= '0;
`ifdef FPU_ARB_NAN_BYPASS_EN
        if (nan_q) begin
          resp_result  <= QNAN;
          resp_flags   <= {snan_q, 4'b0000};
          resp_timeout <= 1'b0;
        end
`endif
      end
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (unit_done) begin
          resp_result  <= unit_result;
          resp_flags   <= unit_flags;
          resp_timeout <= 1'b0;
        end else if (expire) begin
          resp_result  <= QNAN;
          resp_flags   <= 5'b10000;
          resp_timeout <= 1'b1;
        end
      end
      if (hs) ptr_q <= ~resp_id;
    end
  end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb_fpu_issue_arbiter: directed and randomized checks of fpu_issue_arbiter
// against a transaction-level model and a behavioural FP unit stand-in.
module tb_fpu_issue_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        unit_start, unit_abort;
  logic [1:0]  unit_op;
  logic [31:0] unit_a, unit_b;
  logic        unit_done;
  logic [31:0] unit_result;
  logic [4:0]  unit_flags;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags;
  logic        resp_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          hang = 0;
  bit          fix_en = 0;
  int          fix_lat = 3;
  logic [31:0] fix_res = '0;
  logic [4:0]  fix_flg = '0;
  int          late_req = 0;
  int          late_srv = 0;
  int          n_start = 0;

  bit          u_busy = 0;
  int          u_left = 0;
  logic [31:0] u_res;
  logic [4:0]  u_flg;

  fpu_issue_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .unit_start(unit_start), .unit_abort(unit_abort),
    .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result),
    .unit_flags(unit_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fn_res(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  function automatic logic [4:0] fn_flg(
    input logic [1:0] op, input logic [31:0] b);
    return b[4:0] ^ {3'b000, op};
  endfunction

  function automatic int fn_lat(input logic [31:0] a, input logic [31:0] b);
    return 1 + int'(a[1:0]) + int'(b[0]);
  endfunction

  // FP unit stand-in: done pulse N cycles after the start cycle.
  initial begin
    unit_done = 1'b0;
    unit_result = '0;
    unit_flags = '0;
    forever begin
      @(posedge clk);
      #2;
      unit_done = 1'b0;
      if (rst) begin
        u_busy = 0;
      end else begin
        if (unit_abort) u_busy = 0;
        if (late_req != late_srv) begin
          late_srv = late_req;
          unit_done = 1'b1;
          unit_result = 32'hDEAD_BEEF;
          unit_flags = 5'h1F;
        end else if (u_busy) begin
          u_left--;
          if (u_left <= 0) begin
            u_busy = 0;
            unit_done = 1'b1;
            unit_result = u_res;
            unit_flags = u_flg;
          end
        end
        if (unit_start) begin
          n_start++;
          if (!hang) begin
            u_busy = 1;
            if (fix_en) begin
              u_left = fix_lat;
              u_res = fix_res;
              u_flg = fix_flg;
            end else begin
              u_left = fn_lat(unit_a, unit_b);
              u_res = fn_res(unit_op, unit_a, unit_b);
              u_flg = fn_flg(unit_op, unit_b);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    resp_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1; req1_valid = 1;
    resp_ready = 1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    total++;
    if ({unit_start, unit_abort, resp_valid, resp_id, resp_timeout}
        !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000",
        {unit_start, unit_abort, resp_valid, resp_id, resp_timeout});
    end
    total++;
    if ({unit_op, unit_a, unit_b, resp_result, resp_flags} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0",
        {unit_op, unit_a, unit_b, resp_result, resp_flags});
    end
    do_reset();
  endtask

  task automatic test_single();
    int acc;
    bit found;
    int s0;
    do_reset();
    fix_en = 1; fix_lat = 3;
    fix_res = 32'h4040_0000; fix_flg = 5'b0;
    resp_ready = 1;
    s0 = n_start;
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b00;
    req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
    @(negedge clk);
    acc = cyc;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1 req0_valid = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin found = 1; break; end
    end
    total++;
    if (!found || cyc - acc != 5) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=5 found=%0b", cyc - acc, found);
    end
    total++;
    if ({resp_id, resp_result, resp_flags, resp_timeout}
        !== {1'b0, 32'h4040_0000, 5'b0, 1'b0}) begin
      bad++;
      $display("FAIL single_resp got=%b/%h/%b/%b exp=0/40400000/00000/0",
        resp_id, resp_result, resp_flags, resp_timeout);
    end
    total++;
    if (n_start - s0 != 1) begin
      bad++;
      $display("FAIL single_starts got=%0d exp=1", n_start - s0);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_resp_drop got=%b exp=0", resp_valid);
    end
    fix_en = 0;
  endtask

  task automatic test_contention();
    int n_g;
    int n_r;
    int last;
    bit g;
    do_reset();
    resp_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b01;
    req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0001;
    req1_valid = 1; req1_op = 2'b10;
    req1_a = 32'h8765_4322; req1_b = 32'hA5A5_0000;
    n_g = 0; n_r = 0; last = -1;
    for (int i = 0; i < 200 && n_r < 4; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        total++; bad++;
        $display("FAIL contention_dual got=11 exp=one-hot");
      end else if (req0_ready || req1_ready) begin
        g = req1_ready;
        total++;
        if (g !== n_g[0]) begin
          bad++;
          $display("FAIL contention_order n=%0d got=%0d exp=%0d", n_g, g, n_g[0]);
        end
        last = int'(g);
        n_g++;
      end
      if (resp_valid) begin
        total++;
        if (last == 0) begin
          if ({resp_id, resp_result} !== {1'b0, fn_res(req0_op, req0_a, req0_b)}) begin
            bad++;
            $display("FAIL contention_resp0 got=%b/%h exp=0/%h",
              resp_id, resp_result, fn_res(req0_op, req0_a, req0_b));
          end
        end else begin
          if ({resp_id, resp_result} !== {1'b1, fn_res(req1_op, req1_a, req1_b)}) begin
            bad++;
            $display("FAIL contention_resp1 got=%b/%h exp=1/%h",
              resp_id, resp_result, fn_res(req1_op, req1_a, req1_b));
          end
        end
        n_r++;
      end
    end
    total++;
    if (n_r != 4) begin
      bad++;
      $display("FAIL contention_count got=%0d exp=4", n_r);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    bit found;
    logic [31:0] er;
    do_reset();
    resp_ready = 0;
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b11;
    req0_a = 32'h4120_0003; req0_b = 32'h3FC0_0001;
    req1_valid = 1; req1_op = 2'b00;
    req1_a = 32'h0000_0010; req1_b = 32'h0000_0020;
    er = fn_res(req0_op, req0_a, req0_b);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid) begin found = 1; break; end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL bp_resp got=none exp=resp_valid");
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if ({resp_valid, resp_id, resp_result, resp_flags,
           req0_ready, req1_ready}
          !== {1'b1, 1'b0, er, fn_flg(req0_op, req0_b), 2'b00}) begin
        bad++;
        $display("FAIL bp_hold i=%0d got=%b/%b/%h/%b/%b%b exp=1/0/%h/%b/00",
          i, resp_valid, resp_id, resp_result, resp_flags,
          req0_ready, req1_ready, er, fn_flg(req0_op, req0_b));
      end
      @(posedge clk);
    end
    #1 resp_ready = 1;
    @(negedge clk);
    @(posedge clk); #1 resp_ready = 0;
    @(negedge clk);
    total++;
    if ({resp_valid, req0_ready, req1_ready} !== 3'b001) begin
      bad++;
      $display("FAIL bp_next_grant got=%b exp=001",
        {resp_valid, req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_timeout();
    int acc;
    bit found;
    int aborts;
    do_reset();
    hang = 1;
    resp_ready = 0;
    @(posedge clk); #1;
    req1_valid = 1; req1_op = 2'b11;
    req1_a = 32'h4000_0000; req1_b = 32'h0000_0000;
    @(negedge clk);
    acc = cyc;
    @(posedge clk); #1 req1_valid = 0;
    found = 0; aborts = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (unit_abort) aborts++;
      if (resp_valid) begin found = 1; break; end
    end
    total++;
    if (!found || cyc - acc != TMO + 2) begin
      bad++;
      $display("FAIL tmo_latency got=%0d exp=%0d", cyc - acc, TMO + 2);
    end
    total++;
    if (unit_abort !== 1'b1 || aborts != 1) begin
      bad++;
      $display("FAIL tmo_abort got=%b/%0d exp=1/1", unit_abort, aborts);
    end
    total++;
    if ({resp_id, resp_result, resp_flags, resp_timeout}
        !== {1'b1, 32'h7FC0_0000, 5'b10000, 1'b1}) begin
      bad++;
      $display("FAIL tmo_resp got=%b/%h/%b/%b exp=1/7fc00000/10000/1",
        resp_id, resp_result, resp_flags, resp_timeout);
    end
    @(posedge clk); #1 late_req++;
    @(negedge clk);
    total++;
    if (unit_abort !== 1'b0) begin
      bad++;
      $display("FAIL tmo_abort_pulse got=%b exp=0", unit_abort);
    end
    @(negedge clk);
    total++;
    if ({resp_valid, resp_result, resp_flags, resp_timeout}
        !== {1'b1, 32'h7FC0_0000, 5'b10000, 1'b1}) begin
      bad++;
      $display("FAIL tmo_late_done got=%b/%h/%b/%b exp=1/7fc00000/10000/1",
        resp_valid, resp_result, resp_flags, resp_timeout);
    end
    @(posedge clk); #1 resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
    hang = 0;
  endtask

  task automatic test_nan();
    int acc;
    int s0;
    bit found;
    do_reset();
    resp_ready = 1;
    for (int k = 0; k < 2; k++) begin
      s0 = n_start;
      @(posedge clk); #1;
      req1_valid = 1; req1_op = 2'b10;
      req1_a = (k == 0) ? 32'h7F80_0001 : 32'h7FC0_0000;
      req1_b = 32'h3F80_0000;
      @(negedge clk);
      acc = cyc;
      @(posedge clk); #1 req1_valid = 0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (resp_valid) begin found = 1; break; end
      end
`ifdef FPU_ARB_NAN_BYPASS_EN
      total++;
      if (!found || cyc - acc != 2 || n_start != s0) begin
        bad++;
        $display("FAIL nan_bypass k=%0d got=lat%0d/starts%0d exp=lat2/starts0",
          k, cyc - acc, n_start - s0);
      end
      total++;
      if ({resp_result, resp_flags, resp_timeout}
          !== {32'h7FC0_0000, (k == 0) ? 5'b10000 : 5'b00000, 1'b0}) begin
        bad++;
        $display("FAIL nan_resp k=%0d got=%h/%b/%b", k,
          resp_result, resp_flags, resp_timeout);
      end
`else
      total++;
      if (!found || n_start - s0 != 1) begin
        bad++;
        $display("FAIL nan_issue k=%0d got=starts%0d exp=starts1",
          k, n_start - s0);
      end
      total++;
      if (resp_result !== fn_res(req1_op, req1_a, req1_b)) begin
        bad++;
        $display("FAIL nan_result k=%0d got=%h exp=%h", k,
          resp_result, fn_res(req1_op, req1_a, req1_b));
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 0;
    req0_a = 32'h10; req0_b = 32'h20;
    @(posedge clk); #1 req0_valid = 0;
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    hang = 1;
    req1_valid = 1; req1_a = 32'h55; req1_b = 32'h66;
    @(posedge clk); #1 req1_valid = 0;
    repeat (4) @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1 rst = 1;
    #1;
    total++;
    if ({unit_start, unit_abort, resp_valid, resp_id, resp_timeout,
         req0_ready, req1_ready} !== 7'b0) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b exp=0000000",
        {unit_start, unit_abort, resp_valid, resp_id, resp_timeout,
         req0_ready, req1_ready});
    end
    total++;
    if ({unit_op, unit_a, unit_b, resp_result, resp_flags} !== '0) begin
      bad++;
      $display("FAIL midrst_data got=%h exp=0",
        {unit_op, unit_a, unit_b, resp_result, resp_flags});
    end
    hang = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL midrst_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_random();
    bit busy;
    bit mptr;
    int acc;
    int lat;
    bit tid;
    logic [1:0] top;
    logic [31:0] ta, tb;
    bit e0, e1, es, ev;
    do_reset();
    busy = 0; mptr = 0; acc = 0; lat = 0; tid = 0;
    top = 0; ta = 0; tb = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op = 2'($urandom); req0_a = $urandom; req0_b = $urandom;
      req1_op = 2'($urandom); req1_a = $urandom; req1_b = $urandom;
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e0 = !busy && req0_valid && (!req1_valid || !mptr);
      e1 = !busy && req1_valid && (!req0_valid || mptr);
      es = busy && (cyc == acc + 1);
      ev = busy && (cyc >= acc + lat + 2);
      total++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        bad++;
        $display("FAIL rnd_ready n=%0d got=%b exp=%b", n,
          {req0_ready, req1_ready}, {e0, e1});
      end
      total++;
      if (unit_start !== es) begin
        bad++;
        $display("FAIL rnd_start n=%0d got=%b exp=%b", n, unit_start, es);
      end else if (es) begin
        total++;
        if ({unit_op, unit_a, unit_b} !== {top, ta, tb}) begin
          bad++;
          $display("FAIL rnd_unit_ops n=%0d got=%h/%h/%h exp=%h/%h/%h",
            n, unit_op, unit_a, unit_b, top, ta, tb);
        end
      end
      total++;
      if (resp_valid !== ev) begin
        bad++;
        $display("FAIL rnd_resp_valid n=%0d got=%b exp=%b", n, resp_valid, ev);
      end else if (ev) begin
        total++;
        if ({resp_id, resp_result, resp_flags, resp_timeout}
            !== {tid, fn_res(top, ta, tb), fn_flg(top, tb), 1'b0}) begin
          bad++;
          $display("FAIL rnd_resp n=%0d got=%b/%h/%b/%b exp=%b/%h/%b/0",
            n, resp_id, resp_result, resp_flags, resp_timeout,
            tid, fn_res(top, ta, tb), fn_flg(top, tb));
        end
      end
      if (e0 || e1) begin
        busy = 1; acc = cyc; tid = e1;
        top = e1 ? req1_op : req0_op;
        ta = e1 ? req1_a : req0_a;
        tb = e1 ? req1_b : req0_b;
        lat = fn_lat(ta, tb);
      end else if (ev && resp_ready) begin
        busy = 0;
        mptr = ~tid;
      end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_nan();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
